bp_btb: RTL
===========

Name: bp_btb

Overview:
Parametrised branch predictor for the fetch stage of the 5-stage RV32I pipeline.
- Combines a direct-mapped branch target buffer with per-entry saturating direction counters.
- Fetch looks it up in the same cycle to select the next PC.
- Execute updates it when each branch or jump resolves.
- Replaces the fixed "predict not-taken, redirect from EX" behaviour, so taken branches in loops stop costing a flush every iteration.

Parameters:
XLEN, 32, address/data width.
ENTRIES, 64, number of BTB entries; power of 2, minimum 4.
CTR_W, 2, direction counter width; minimum 1.
IDX_W, $clog2(ENTRIES), derived index width; not to be overridden.
TAG_W, XLEN-IDX_W-2, derived tag width.

Ports:
i_clk  in  1  clock, rising edge.
i_rst  in  1  asynchronous reset, active-high.
i_fetch_pc  in  XLEN  PC being fetched this cycle.
o_pred_hit  out  1  valid entry with matching tag (combinational).
o_pred_taken  out  1  predicted taken (combinational).
o_pred_target  out  XLEN  stored target on hit, else 0.
o_next_pc  out  XLEN  o_pred_taken ? o_pred_target : i_fetch_pc+4.
i_upd_vld  in  1  resolved control-flow instruction in EX this cycle.
i_upd_pc  in  XLEN  PC of the resolved instruction.
i_upd_is_jmp  in  1  1 = JAL/JALR, 0 = conditional branch.
i_upd_taken  in  1  actual outcome.
i_upd_target  in  XLEN  actual target.
i_upd_mispred  in  1  EX redirected fetch (used only by stats).
i_flush_all  in  1  invalidate every entry (e.g. fence.i).

Behaviour:
- Indexing: index = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2]. pc[1:0] is ignored.
- Entry fields: valid, tag, target, is_jmp, ctr[CTR_W-1:0].
- Reset (async, i_rst=1):
  - All valid=0.
  - All ctr = 2^(CTR_W-1)-1 (weakly not-taken); tags and targets = 0.
  - Outputs therefore settle to hit=0, taken=0, target=0, next_pc=i_fetch_pc+4.
  - Reset asserted mid-update discards that update.
- Lookup (zero latency, pure read of current state):
  - hit = valid & tag match.
  - taken = hit & (is_jmp | ctr[CTR_W-1]).
- Update (registered, visible from the next cycle) when i_upd_vld=1:
  - Tag hit, branch: ctr +1 if taken, -1 if not; saturates at 0 and 2^CTR_W-1. target is overwritten only if taken.
  - Tag hit, jump: target overwritten, is_jmp=1, ctr=max.
  - Miss, taken: allocate and overwrite any existing entry. Set valid=1, tag, target, is_jmp, ctr = 2^(CTR_W-1) (weakly taken); jumps get ctr=max.
  - Miss, not-taken: no change; no allocation.
- Same-cycle update and lookup to the same index: lookup returns pre-update contents (read-before-write).
- i_flush_all=1:
  - All valid cleared at the next edge; counters and targets untouched.
  - Takes priority over a simultaneous update, which is dropped.
- No stall input: the block is stateless except for its table. A stalled fetch simply re-presents the same PC.
- Address arithmetic is modulo 2^XLEN: pc+4 wraps, 0xFFFFFFFC -> 0x00000000.

Optional Feature:
Macro BP_STATS_EN.
- Defined:
  - Adds ports o_stat_lookups, o_stat_updates, o_stat_mispred (32-bit each, out).
  - o_stat_lookups counts every non-reset cycle.
  - o_stat_updates counts cycles with i_upd_vld=1.
  - o_stat_mispred counts cycles with i_upd_vld & i_upd_mispred.
  - All three saturate at 0xFFFFFFFF and reset to 0.
  - i_flush_all does not clear them.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package bp_pkg:
  - Counter-state localparams SNT/WNT/WT/ST for the CTR_W=2 default.
  - Typedef bp_entry_t packed struct {valid, tag, target, is_jmp, ctr}.
  - Function bp_index/bp_tag extraction helpers, parametrised by IDX_W.
- Sub-module bp_sat_ctr: combinational next-state of a CTR_W saturating counter (inputs ctr, taken, force_max). Instantiated once on the update path.

Test Plan:
1. Reset, then lookup 0x00000100 -> hit=0, taken=0, next_pc=0x00000104.
2. Update pc=0x100, branch, taken, target=0x40; next cycle lookup 0x100 -> hit=1, taken=1, next_pc=0x40, ctr=2.
3. Then 3 not-taken updates to 0x100 -> ctr 1, 0, 0 (saturated), taken=0 after the first. Then 4 taken updates -> ctr 1, 2, 3, 3, taken=1 from ctr=2.
4. Aliasing, using 0x100 and 0x200 (same index 0, different tag):
   - Entry for 0x100 valid; lookup 0x200 -> hit=0.
   - Not-taken update 0x200 -> no change, 0x100 still hits.
   - Taken JAL update 0x200, target=0x80 -> 0x200 hits with taken=1; 0x100 misses.
5. Same cycle: taken update 0x300 -> target 0x10 plus lookup 0x300 -> that cycle hit=0; next cycle hit=1, next_pc=0x10. Also lookup 0xFFFFFFFC on empty table -> next_pc=0x0.
6. i_flush_all together with a taken update to 0x400 -> next cycle, lookups of 0x100 and 0x400 both miss. With BP_STATS_EN, 5 updates (2 mispredicted) over 20 cycles -> updates=5, mispred=2, lookups=20.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and helpers for the fetch-stage branch predictor.
// Optional statistics counters in bp_btb are enabled by BP_STATS_EN.
package bp_pkg;

  // Direction counter states for the 2-bit default counter.
  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  // Entry layout for the default geometry (XLEN=32, ENTRIES=64, CTR_W=2).
  typedef struct packed {
    logic        valid;
    logic [23:0] tag;
    logic [31:0] target;
    logic        is_jmp;
    logic [1:0]  ctr;
  } bp_entry_t;

  // Word index: pc[idx_w+1:2].
  function automatic logic [63:0] bp_index(
    input logic [63:0] pc,
    input int unsigned idx_w
  );
    return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  // Tag: everything above the index bits.
  function automatic logic [63:0] bp_tag(
    input logic [63:0] pc,
    input int unsigned idx_w
  );
    return pc >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// Next-state logic of a saturating direction counter.
// force_max pins the counter to its strongest taken value.
module bp_sat_ctr #(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr,
  input  logic             taken,
  input  logic             force_max,
  output logic [CTR_W-1:0] nxt
);

  // Step toward the outcome, holding at either end.
  always_comb begin
    nxt = ctr;
    if (force_max)
      nxt = '1;
    else if (taken && (ctr != '1))
      nxt = ctr + CTR_W'(1);
    else if (!taken && (ctr != '0))
      nxt = ctr - CTR_W'(1);
  end

endmodule

// File: rtl/bp_btb.sv
// Direct-mapped BTB with per-entry direction counters for fetch.
// Define BP_STATS_EN to add lookup/update/mispredict counters.
module bp_btb
  import bp_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64,
  parameter int CTR_W   = 2,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int TAG_W   = XLEN - IDX_W - 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [XLEN-1:0] i_fetch_pc,
  output logic            o_pred_hit,
  output logic            o_pred_taken,
  output logic [XLEN-1:0] o_pred_target,
  output logic [XLEN-1:0] o_next_pc,
  input  logic            i_upd_vld,
  input  logic [XLEN-1:0] i_upd_pc,
  input  logic            i_upd_is_jmp,
  input  logic            i_upd_taken,
  input  logic [XLEN-1:0] i_upd_target,
  input  logic            i_upd_mispred,
`ifdef BP_STATS_EN
  output logic [31:0]     o_stat_lookups,
  output logic [31:0]     o_stat_updates,
  output logic [31:0]     o_stat_mispred,
`endif
  input  logic            i_flush_all
);

  localparam logic [CTR_W-1:0] CTR_WNT =
    CTR_W'((1 << (CTR_W - 1)) - 1);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [XLEN-1:0]    tgt_q [ENTRIES];
  logic               jmp_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_q [ENTRIES];

  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;
  logic [CTR_W-1:0] ctr_in;
  logic [CTR_W-1:0] ctr_nxt;

  assign f_idx = IDX_W'(bp_index(64'(i_fetch_pc), IDX_W));
  assign f_tag = TAG_W'(bp_tag(64'(i_fetch_pc), IDX_W));
  assign u_idx = IDX_W'(bp_index(64'(i_upd_pc), IDX_W));
  assign u_tag = TAG_W'(bp_tag(64'(i_upd_pc), IDX_W));

  // Zero-latency lookup of the current table contents.
  always_comb begin
    o_pred_hit    = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    o_pred_taken  = o_pred_hit &&
                    (jmp_q[f_idx] || ctr_q[f_idx][CTR_W-1]);
    o_pred_target = o_pred_hit ? tgt_q[f_idx] : '0;
    o_next_pc     = o_pred_taken ? o_pred_target
                                 : i_fetch_pc + XLEN'(4);
  end

  assign u_hit  = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  // A fresh allocation steps up from weakly not-taken to weakly taken.
  assign ctr_in = u_hit ? ctr_q[u_idx] : CTR_WNT;

  bp_sat_ctr #(.CTR_W(CTR_W)) u_ctr (
    .ctr       (ctr_in),
    .taken     (i_upd_taken),
    .force_max (i_upd_is_jmp),
    .nxt       (ctr_nxt)
  );

  // Table write: flush beats update; misses allocate only when taken.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        jmp_q[i] <= 1'b0;
        ctr_q[i] <= CTR_WNT;
      end
    end else if (i_flush_all) begin
      valid_q <= '0;
    end else if (i_upd_vld) begin
      if (u_hit) begin
        ctr_q[u_idx] <= ctr_nxt;
        if (i_upd_is_jmp) begin
          jmp_q[u_idx] <= 1'b1;
          tgt_q[u_idx] <= i_upd_target;
        end else if (i_upd_taken) begin
          tgt_q[u_idx] <= i_upd_target;
        end
      end else if (i_upd_taken) begin
        valid_q[u_idx] <= 1'b1;
        tag_q[u_idx]   <= u_tag;
        tgt_q[u_idx]   <= i_upd_target;
        jmp_q[u_idx]   <= i_upd_is_jmp;
        ctr_q[u_idx]   <= ctr_nxt;
      end
    end
  end

`ifdef BP_STATS_EN
  // Saturating activity counters; a table flush leaves them alone.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_stat_lookups <= '0;
      o_stat_updates <= '0;
      o_stat_mispred <= '0;
    end else begin
      if (o_stat_lookups != '1)
        o_stat_lookups <= o_stat_lookups + 32'd1;
      if (i_upd_vld && (o_stat_updates != '1))
        o_stat_updates <= o_stat_updates + 32'd1;
      if (i_upd_vld && i_upd_mispred && (o_stat_mispred != '1))
        o_stat_mispred <= o_stat_mispred + 32'd1;
    end
  end
`else
  logic unused_mispred;
  assign unused_mispred = i_upd_mispred;
`endif

endmodule
